// File: rtl/mux2_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_arb_pkg
//  Brief    : Shared types and constants for the mux2 arbiter slice.
//  Revision : 1.0 - initial release
// ============================================================================
package mux2_arb_pkg;

   // Arbiter FSM states: waiting for a winner, or locked to requester 0/1
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } state_t;

   localparam logic SEL_I0 = 1'b0;
   localparam logic SEL_I1 = 1'b1;

   // Width of the mid-packet stall counter
   localparam int CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/mux2_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_arbiter_if
//  Brief    : Bundle of the two requester handshakes, the muxed output
//             stream and the select/error status of the mux2 arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface mux2_arbiter_if #(
   parameter int DW = 8
);
   logic          i0_valid;
   logic [DW-1:0] i0_data;
   logic          i0_last;
   logic          i0_ready;

   logic          i1_valid;
   logic [DW-1:0] i1_data;
   logic          i1_last;
   logic          i1_ready;

   logic          y_valid;
   logic [DW-1:0] y_data;
   logic          y_last;
   logic          y_ready;

   logic          sel;
   logic          timeout_err;

   // Environment side: drives requesters and the downstream ready
   modport master (
      output i0_valid, i0_data, i0_last, input i0_ready,
      output i1_valid, i1_data, i1_last, input i1_ready,
      input  y_valid, y_data, y_last, output y_ready,
      input  sel, timeout_err
   );

   // Arbiter side
   modport slave (
      input  i0_valid, i0_data, i0_last, output i0_ready,
      input  i1_valid, i1_data, i1_last, output i1_ready,
      output y_valid, y_data, y_last, input y_ready,
      output sel, timeout_err
   );
endinterface
`default_nettype wire

// File: rtl/mux2_out_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_out_stage
//  Brief    : Single-entry registered valid/ready output stage. Loads a beat
//             whenever the upstream handshake completes; holds it until the
//             downstream consumer takes it.
//  Revision : 1.0 - initial release
// ============================================================================
module mux2_out_stage #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_load,
   input  logic [DW-1:0] i_data,
   input  logic          i_last,
   input  logic          i_ready,
   output logic          o_valid,
   output logic [DW-1:0] o_data,
   output logic          o_last
);
   logic          r_valid;
   logic [DW-1:0] r_data;
   logic          r_last;

   // Output register: load on accept, drop valid once drained with no refill
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_last  <= i_last;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/mux2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_arbiter
//  Brief    : Round-robin packet arbiter for a 2:1 mux. Locks the grant for a
//             whole packet, feeds a registered output stage, and force-
//             releases a grant whose owner stalls for TIMEOUT cycles.
//  Config   : define MUX2_ARB_ASSERT_EN to compile in protocol assertions.
//  Revision : 1.0 - initial release
// ============================================================================
module mux2_arbiter
   import mux2_arb_pkg::*;
#(
   parameter int DW      = 8,
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   mux2_arbiter_if.slave bus
);
   localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_ptr;
   logic             w_ptr_nxt;
   logic             r_sel;
   logic             w_sel;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             r_tmo;
   logic             w_tmo_nxt;
   logic             w_rdy0;
   logic             w_rdy1;
   logic             w_accept;
   logic             w_beat_last;
   logic             w_own_valid;
   logic             w_any_valid;
   logic             w_winner;
   logic             w_can_load;
   logic             w_y_valid;
   logic [DW-1:0]    w_beat_data;

   assign w_can_load  = !w_y_valid || bus.y_ready;
   assign w_any_valid = bus.i0_valid || bus.i1_valid;
   // A lone requester wins outright; a tie goes to the favoured one
   assign w_winner    = (bus.i0_valid && bus.i1_valid) ? r_ptr : bus.i1_valid;
   assign w_cnt_inc   = r_cnt + CNT_W'(1);

   // Grant, ready generation, next-state, pointer and watchdog decisions
   always_comb begin
      w_sel       = r_sel;
      w_rdy0      = 1'b0;
      w_rdy1      = 1'b0;
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_tmo_nxt   = 1'b0;
      w_accept    = 1'b0;
      w_beat_last = 1'b0;
      w_own_valid = 1'b0;

      // No handshake may open while reset is asserted
      if (!rst) begin
         case (r_state)
            IDLE:    if (w_any_valid) w_sel = w_winner;
            BUSY0:   w_sel = SEL_I0;
            BUSY1:   w_sel = SEL_I1;
            default: w_sel = r_sel;
         endcase
         if (r_state != IDLE || w_any_valid) begin
            w_rdy0 = w_can_load && (w_sel == SEL_I0);
            w_rdy1 = w_can_load && (w_sel == SEL_I1);
         end
      end

      w_beat_last = (w_sel == SEL_I1) ? bus.i1_last  : bus.i0_last;
      w_own_valid = (w_sel == SEL_I1) ? bus.i1_valid : bus.i0_valid;
      w_accept    = (w_rdy0 && bus.i0_valid) || (w_rdy1 && bus.i1_valid);

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_beat_last) w_ptr_nxt   = ~w_sel;
               else             w_state_nxt = (w_sel == SEL_I1) ? BUSY1 : BUSY0;
            end
         end
         BUSY0, BUSY1: begin
            if (w_accept) begin
               w_cnt_nxt = '0;
               if (w_beat_last) begin
                  w_state_nxt = IDLE;
                  w_ptr_nxt   = ~w_sel;
               end
            end else if (!w_own_valid) begin
               // Only owner starvation counts; downstream backpressure does not
               if (w_cnt_inc == c_TIMEOUT) begin
                  w_state_nxt = IDLE;
                  w_ptr_nxt   = ~w_sel;
                  w_cnt_nxt   = '0;
                  w_tmo_nxt   = 1'b1;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Arbiter state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= 1'b0;
         r_sel   <= SEL_I0;
         r_cnt   <= '0;
         r_tmo   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_sel   <= w_sel;
         r_cnt   <= w_cnt_nxt;
         r_tmo   <= w_tmo_nxt;
      end
   end

   assign w_beat_data = (w_sel == SEL_I1) ? bus.i1_data : bus.i0_data;

   mux2_out_stage #(
      .DW (DW)
   ) u_out_stage (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_accept),
      .i_data  (w_beat_data),
      .i_last  (w_beat_last),
      .i_ready (bus.y_ready),
      .o_valid (w_y_valid),
      .o_data  (bus.y_data),
      .o_last  (bus.y_last)
   );

   assign bus.y_valid     = w_y_valid;
   assign bus.i0_ready    = w_rdy0;
   assign bus.i1_ready    = w_rdy1;
   assign bus.sel         = w_sel;
   assign bus.timeout_err = r_tmo;

`ifdef MUX2_ARB_ASSERT_EN
   a_one_ready: assert property (@(posedge clk) disable iff (rst)
      !(bus.i0_ready && bus.i1_ready));

   a_sel_busy: assert property (@(posedge clk) disable iff (rst)
      (r_state != IDLE && w_state_nxt == r_state) |=> $stable(bus.sel));

   a_y_hold: assert property (@(posedge clk) disable iff (rst)
      (bus.y_valid && !bus.y_ready) |=> ($stable(bus.y_data) && $stable(bus.y_last)));

   a_tmo_pulse: assert property (@(posedge clk) disable iff (rst)
      bus.timeout_err |=> !bus.timeout_err);

   a_hold_v0: assert property (@(posedge clk) disable iff (rst)
      (r_state == IDLE && bus.i0_valid && bus.sel == SEL_I0 && !w_accept) |=> bus.i0_valid);

   a_hold_v1: assert property (@(posedge clk) disable iff (rst)
      (r_state == IDLE && bus.i1_valid && bus.sel == SEL_I1 && !w_accept) |=> bus.i1_valid);
`endif

endmodule
`default_nettype wire

// File: doc/mux2_arbiter.md
# mux2_arbiter

Round-robin arbiter and sequencer for the 2:1 mux datapath. Two requesters present packets over valid/ready handshakes. The block selects one, drives the mux select, and holds the grant until that packet's last beat passes. The muxed stream leaves through a registered valid/ready output stage. A watchdog releases a grant whose owner stalls mid-packet.

## Interface
- `DW`, default 8: data width per beat.
- `TIMEOUT`, default 15: consecutive stalled cycles mid-packet before a forced release; legal range 1..255.
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `i0_valid` in 1, `i0_data` in DW, `i0_last` in 1, `i0_ready` out 1: requester 0.
- `i1_valid` in 1, `i1_data` in DW, `i1_last` in 1, `i1_ready` out 1: requester 1.
- `y_valid` out 1, `y_data` out DW, `y_last` out 1, `y_ready` in 1: muxed output stream.
- `sel` out 1: current mux select (0 = i0, 1 = i1).
- `timeout_err` out 1: one-cycle pulse on a forced release.

## Operation
- **States:** IDLE, BUSY0, BUSY1.
- **Priority pointer:** `ptr` names the favoured requester.
- **`can_load`:** `!y_valid || y_ready`.
- **IDLE, winner selection:**
  - If only one requester is valid, it wins.
  - If both are valid, requester `ptr` wins.
  - If neither is valid, stay in IDLE.
  - `sel` = winner combinationally, otherwise it holds its last value.
- **IDLE, first beat:** `iK_ready = can_load` for the winner. If the beat is accepted:
  - with `iK_last`=1: stay in IDLE and set `ptr` = ~K;
  - otherwise: go to BUSYK.
  - If `can_load`=0, nothing is accepted and arbitration repeats next cycle. Once presented, the winner's `valid` must not drop.
- **BUSYK:**
  - `sel` = K.
  - `iK_ready = can_load`. The other requester's `ready` = 0.
  - When a beat with `last`=1 is accepted: go to IDLE, `ptr` = ~K.
- **Ready rules:** at most one `ready` is high in any cycle. No `ready` is high during reset.
- **Output stage:** on an accepted beat, `y_data`/`y_last` load the selected requester's data, and `y_valid` sets. `y_valid` clears when `y_ready`=1 and no new beat loads. `y_data`/`y_last` are stable while `y_valid && !y_ready`.
- **Watchdog:**
  - In BUSYK, an 8-bit counter increments on each cycle with `iK_valid`=0. It clears on any accepted beat and on leaving BUSY.
  - When the counter reaches `TIMEOUT`: go to IDLE, set `ptr` = ~K, pulse `timeout_err` for one cycle. No beat is emitted for the truncated packet. Downstream sees a packet without `last`.
  - Stalls caused by `y_ready`=0 never count.
- **Reset mid-packet:** abandon the packet and enter IDLE. Any beat held in the output register is discarded (`y_valid`=0).

## Timing
- **Reset values:** `y_valid`=0, `y_data`=0, `y_last`=0, `sel`=0, `i0_ready`=0, `i1_ready`=0, `timeout_err`=0, state=IDLE, `ptr`=0, counter=0.
- **Latency:** one cycle, from input beat accepted to that beat on `y_*`.
- **Throughput:** one beat per cycle while the output is drained each cycle (`y_ready` held high).
- **Packet boundary:** a new packet may be accepted the cycle after the previous `last` is accepted. No bubble is required when the other requester is already valid.
- **Simultaneous events:**
  - `last` accepted and the watchdog hitting `TIMEOUT` in the same cycle: impossible, because an accept clears the counter.
  - `rst` wins over every other event.

## Configuration
- **`MUX2_ARB_ASSERT_EN` defined:** compiles in concurrent assertions, all with `disable iff (rst)`:
  - `i0_ready && i1_ready` never both high;
  - `sel` stable in BUSY states;
  - `y_data`/`y_last` stable while `y_valid && !y_ready`;
  - `timeout_err` is a single-cycle pulse (`|=> !timeout_err`);
  - the winner's `valid` held after being presented in IDLE.
- **Undefined:** no assertions are compiled. RTL behaviour is identical in both cases.

## Structure
- **Package `mux2_arb_pkg`:** state enum typedef (IDLE, BUSY0, BUSY1), `SEL_I0`/`SEL_I1` constants, counter width constant (8).
- **Sub-module `mux2_out_stage`:** a registered valid/ready output stage, parameterised on `DW`, instantiated once. The arbiter FSM, pointer and watchdog stay in `mux2_arbiter`.

## Test plan
- **Single-beat alternation:** after reset, both valid every cycle, all `last`=1, `y_ready`=1. Required: `sel` alternates 0,1,0,1. `y_data` alternates i0/i1 values (e.g. 0xA0, 0xB1, 0xA2, …) with one-cycle latency.
- **Multi-beat lock:** i0 sends 3 beats (0x10, 0x11, 0x12 with `last`). i1 is valid throughout. Required: `i1_ready`=0 until 0x12 is accepted. The next output beat comes from i1.
- **Backpressure:** hold `y_ready`=0 for 4 cycles with `y_valid`=1. Required: `y_data` stays constant, both `ready` outputs are 0, and no `timeout_err` fires.
- **Watchdog:** i1 sends 1 non-last beat, then drops `valid`, with `TIMEOUT`=15. Required: `timeout_err` is high for exactly one cycle, 15 cycles after the stall starts. State returns to IDLE with `ptr`=0.
- **Reset mid-packet:** assert `rst` during beat 2 of a 4-beat i0 packet. Required: the next cycle shows all outputs at reset values. The following arbitration favours i0 (`ptr`=0).
- **Idle start:** only i1 valid after reset, a single beat 0x5C with `last`=1. Required: `sel`=1 and `i1_ready`=1 in the first cycle. Next cycle `y_data`=0x5C, `y_last`=1.
